// File: rtl/ws2812b_strip_sequencer.sv
// WS2812B strip sequencer: TinyQV byte-bus peripheral that streams a 4-pixel
// G,R,B pattern across up to 255 LEDs on a single one-wire output, followed
// by the strip latch period.
// Optional feature: define WS2812B_BRIGHTNESS_EN to add the BRIGHT register at
// address 0x2. Each fetched byte is then scaled by (BRIGHT+1)/256.
module ws2812b_strip_sequencer #(
    parameter int T0H_CYC   = 26,
    parameter int T1H_CYC   = 51,
    parameter int BIT_CYC   = 80,
    parameter int LATCH_CYC = 19200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       led_out,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // Terminal counts; the cycle counter runs 0..N-1 in every timed state.
    localparam logic [14:0] LP_T0H_LAST   = 15'(T0H_CYC - 1);
    localparam logic [14:0] LP_T1H_LAST   = 15'(T1H_CYC - 1);
    localparam logic [14:0] LP_T0L_LAST   = 15'(BIT_CYC - T0H_CYC - 1);
    localparam logic [14:0] LP_T1L_LAST   = 15'(BIT_CYC - T1H_CYC - 1);
    localparam logic [14:0] LP_LATCH_LAST = 15'(LATCH_CYC - 1);

    state_t      r_state;
    logic        r_led_out;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_led_count;
    logic [7:0]  r_buf [0:11];
    logic [14:0] r_cyc;
    logic [2:0]  r_bit;      // bit position within the current byte
    logic [1:0]  r_byte;     // byte position (G,R,B) within the current pixel
    logic [7:0]  r_leds;     // LEDs remaining in the frame, including the current one
    logic [1:0]  r_pix;      // pixel pattern index, wraps modulo 4
    logic [7:0]  r_shift;

    logic        w_wr_ctrl;
    logic        w_start;
    logic        w_abort;
    logic [14:0] w_th_last;
    logic [14:0] w_tl_last;
    logic [1:0]  w_fetch_pix;
    logic [1:0]  w_fetch_k;
    logic [3:0]  w_fetch_idx;
    logic [7:0]  w_raw_byte;
    logic [7:0]  w_fetch_byte;
    logic [3:0]  w_rd_idx;

    assign w_wr_ctrl = data_write && (address == 4'h0);
    assign w_abort   = w_wr_ctrl && data_in[1];
    assign w_start   = w_wr_ctrl && data_in[0] && !data_in[1];

    // High and low phase lengths both follow the MSB being transmitted.
    assign w_th_last = r_shift[7] ? LP_T1H_LAST : LP_T0H_LAST;
    assign w_tl_last = r_shift[7] ? LP_T1L_LAST : LP_T0L_LAST;

    assign w_rd_idx = address - 4'h4;

`ifdef WS2812B_BRIGHTNESS_EN
    logic [7:0] r_bright;

    // Scale a colour byte: (b * (br + 1)) >> 8, upper byte of the 16-bit product.
    function automatic logic [7:0] f_scale(input logic [7:0] b, input logic [7:0] br);
        logic [16:0] prod;
        prod = {9'd0, b} * ({9'd0, br} + 17'd1);
        return prod[15:8];
    endfunction

    // BRIGHT register, full scale out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bright <= 8'hFF;
        end else if (data_write && (address == 4'h2)) begin
            r_bright <= data_in;
        end else begin
            r_bright <= r_bright;
        end
    end

    assign w_fetch_byte = f_scale(w_raw_byte, r_bright);
`else
    assign w_fetch_byte = w_raw_byte;
`endif

    // Locate the buffer byte that is shifted out next (sampled when it is loaded)
    always_comb begin
        w_fetch_pix = r_pix;
        w_fetch_k   = 2'd0;
        if (r_state == ST_IDLE) begin
            w_fetch_pix = 2'd0;
            w_fetch_k   = 2'd0;
        end else if (r_byte == 2'd2) begin
            w_fetch_pix = r_pix + 2'd1;
            w_fetch_k   = 2'd0;
        end else begin
            w_fetch_pix = r_pix;
            w_fetch_k   = r_byte + 2'd1;
        end
        w_fetch_idx = {1'b0, w_fetch_pix, 1'b0} + {2'b00, w_fetch_pix} + {2'b00, w_fetch_k};
        w_raw_byte  = r_buf[w_fetch_idx];
    end

    // Host writes to LED_COUNT and the pixel buffer; both may change mid-frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led_count <= 8'h00;
            for (int i = 0; i < 12; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else if (data_write) begin
            if (address == 4'h1) begin
                r_led_count <= data_in;
            end else if (address >= 4'h4) begin
                r_buf[w_rd_idx] <= data_in;
            end else begin
                r_led_count <= r_led_count;
            end
        end else begin
            r_led_count <= r_led_count;
        end
    end

    // Frame sequencer: bit timing, byte fetch, LED count and latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_led_out <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cyc     <= 15'd0;
            r_bit     <= 3'd0;
            r_byte    <= 2'd0;
            r_leds    <= 8'd0;
            r_pix     <= 2'd0;
            r_shift   <= 8'h00;
        end else if (w_abort && r_busy) begin
            // Abort always ends in a complete latch period so the strip resyncs.
            r_state   <= ST_LATCH;
            r_led_out <= 1'b0;
            r_cyc     <= 15'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_leds <= r_led_count;
                        r_done <= 1'b0;
                        r_busy <= 1'b1;
                        r_cyc  <= 15'd0;
                        r_bit  <= 3'd0;
                        r_byte <= 2'd0;
                        r_pix  <= 2'd0;
                        if (r_led_count == 8'd0) begin
                            r_state   <= ST_LATCH;
                            r_led_out <= 1'b0;
                        end else begin
                            r_state   <= ST_HIGH;
                            r_led_out <= 1'b1;
                            r_shift   <= w_fetch_byte;
                        end
                    end
                end
                ST_HIGH: begin
                    if (r_cyc == w_th_last) begin
                        r_state   <= ST_LOW;
                        r_led_out <= 1'b0;
                        r_cyc     <= 15'd0;
                    end else begin
                        r_cyc <= r_cyc + 15'd1;
                    end
                end
                ST_LOW: begin
                    if (r_cyc == w_tl_last) begin
                        r_cyc <= 15'd0;
                        if (r_bit != 3'd7) begin
                            r_bit     <= r_bit + 3'd1;
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_state   <= ST_HIGH;
                            r_led_out <= 1'b1;
                        end else if (r_byte != 2'd2) begin
                            r_bit     <= 3'd0;
                            r_byte    <= r_byte + 2'd1;
                            r_shift   <= w_fetch_byte;
                            r_state   <= ST_HIGH;
                            r_led_out <= 1'b1;
                        end else if (r_leds == 8'd1) begin
                            r_bit     <= 3'd0;
                            r_state   <= ST_LATCH;
                            r_led_out <= 1'b0;
                        end else begin
                            r_bit     <= 3'd0;
                            r_byte    <= 2'd0;
                            r_pix     <= r_pix + 2'd1;
                            r_leds    <= r_leds - 8'd1;
                            r_shift   <= w_fetch_byte;
                            r_state   <= ST_HIGH;
                            r_led_out <= 1'b1;
                        end
                    end else begin
                        r_cyc <= r_cyc + 15'd1;
                    end
                end
                ST_LATCH: begin
                    if (r_cyc == LP_LATCH_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cyc   <= 15'd0;
                    end else begin
                        r_cyc <= r_cyc + 15'd1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_led_out <= 1'b0;
                    r_busy    <= 1'b0;
                    r_cyc     <= 15'd0;
                end
            endcase
        end
    end

    // Combinational register read mux
    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0: data_out = {6'b000000, r_done, r_busy};
            4'h1: data_out = r_led_count;
`ifdef WS2812B_BRIGHTNESS_EN
            4'h2: data_out = r_bright;
`else
            4'h2: data_out = 8'h00;
`endif
            4'h3: data_out = 8'h00;
            default: data_out = r_buf[w_rd_idx];
        endcase
    end

    assign led_out = r_led_out;
    assign busy    = r_busy;

endmodule

// File: tb/tb_ws2812b_strip_sequencer.sv
// Self-checking bench for ws2812b_strip_sequencer: register table vectors plus
// hand-written frame, abort, zero-length and reset sequences.
module tb_ws2812b_strip_sequencer;

    localparam int T0H   = 26;
    localparam int T1H   = 51;
    localparam int BITC  = 80;
    localparam int LATCH = 19200;
`ifdef WS2812B_BRIGHTNESS_EN
    localparam logic [7:0] BR_RD = 8'hFF;
`else
    localparam logic [7:0] BR_RD = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       led_out;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       do_wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] pix_tab [12];
    bit         exp_bits [$];

    // mid-frame host writes, issued during the low phase after the given bit
    int         inj_bit0 = -1;
    int         inj_bit1 = -1;
    logic [3:0] inj_a0, inj_a1;
    logic [7:0] inj_d0, inj_d1;
    logic       pend_v = 1'b0;
    logic [3:0] pend_a;
    logic [7:0] pend_d;

    ws2812b_strip_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .led_out    (led_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            exp_bits.push_back(b[i]);
        end
    endtask

    // Count consecutive cycles with led_out at lvl, issuing any pending write.
    task automatic run_len(input logic lvl, input int maxc, output int n);
        n = 0;
        while (led_out == lvl && n < maxc) begin
            if (pend_v) begin
                address    = pend_a;
                data_in    = pend_d;
                data_write = 1'b1;
                pend_v     = 1'b0;
            end else begin
                data_write = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        data_write = 1'b0;
    endtask

    // Count cycles that are busy with the line held low.
    task automatic run_busy_low(input int maxc, output int n);
        n = 0;
        while (busy && !led_out && n < maxc) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Check every bit of exp_bits. last_limit = 0: the final bit is followed by
    // more data; otherwise the final low (low phase + latch) is counted up to it.
    task automatic check_frame(input string tag, input int last_limit, output int total);
        int h, l, th, exp_last;
        total = 0;
        for (int i = 0; i < exp_bits.size(); i++) begin
            th = exp_bits[i] ? T1H : T0H;
            run_len(1'b1, 200, h);
            check($sformatf("%s bit%0d high", tag, i), h, th);
            total += h;
            if (i == inj_bit0) begin
                pend_v = 1'b1; pend_a = inj_a0; pend_d = inj_d0;
            end
            if (i == inj_bit1) begin
                pend_v = 1'b1; pend_a = inj_a1; pend_d = inj_d1;
            end
            if (i != exp_bits.size() - 1 || last_limit == 0) begin
                run_len(1'b0, 200, l);
                check($sformatf("%s bit%0d low", tag, i), l, BITC - th);
            end else begin
                exp_last = BITC - th + LATCH;
                if (last_limit < exp_last) exp_last = last_limit;
                run_busy_low(last_limit, l);
                check($sformatf("%s last low", tag), l, exp_last);
            end
            total += l;
        end
    endtask

    initial begin
        int n, total;

        vecs[0] = '{1'b1, 4'h1, 8'h5A, 8'h5A};
        vecs[1] = '{1'b1, 4'h3, 8'hAA, 8'h00};
        vecs[2] = '{1'b1, 4'h2, 8'hFF, BR_RD};
        vecs[3] = '{1'b1, 4'h4, 8'h12, 8'h12};
        vecs[4] = '{1'b1, 4'hF, 8'hFE, 8'hFE};
        vecs[5] = '{1'b1, 4'h9, 8'h77, 8'h77};
        vecs[6] = '{1'b1, 4'h0, 8'h02, 8'h00};
        vecs[7] = '{1'b1, 4'h0, 8'h03, 8'h00};
        vecs[8] = '{1'b0, 4'h1, 8'h00, 8'h5A};
        vecs[9] = '{1'b0, 4'h4, 8'h00, 8'h12};
        pix_tab = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E,
                    8'h55, 8'hAA, 8'h01, 8'hC3, 8'h18, 8'hE7};

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset led_out", led_out, 0);
        check("reset busy", busy, 0);
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            #1;
            check($sformatf("reset read addr%0h", a), data_out, (a == 2) ? BR_RD : 8'h00);
        end

        // register table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
            else @(negedge clk);
            address = vecs[i].addr;
            #1;
            check($sformatf("reg vec%0d addr%0h", i, vecs[i].addr), data_out, vecs[i].exp);
            check($sformatf("reg vec%0d busy", i), busy, 0);
            check($sformatf("reg vec%0d led_out", i), led_out, 0);
        end

        // single LED: G=0x80 R=0x00 B=0x01; latch observed for its first cycles
        wr(4'h4, 8'h80); wr(4'h5, 8'h00); wr(4'h6, 8'h01); wr(4'h1, 8'h01);
        exp_bits.delete();
        push_byte(8'h80); push_byte(8'h00); push_byte(8'h01);
        wr(4'h0, 8'h01);
        check("t1 led rises", led_out, 1);
        check("t1 ctrl busy", data_out, 8'h01);
        check_frame("t1", 29 + 100, total);
        check("t1 busy in latch", busy, 1);
        // reset during latch
        rst = 1'b1;
        @(negedge clk);
        check("rst latch led_out", led_out, 0);
        check("rst latch busy", busy, 0);
        rst = 1'b0;
        address = 4'h1; #1; check("rst led_count", data_out, 8'h00);
        address = 4'h4; #1; check("rst pixel0 G", data_out, 8'h00);

        // six LEDs, four distinct pixels, with ignored START and LED_COUNT write mid-frame
        for (int k = 0; k < 12; k++) wr(4'(4 + k), pix_tab[k]);
        wr(4'h1, 8'd6);
        exp_bits.delete();
        for (int led = 0; led < 6; led++) begin
            for (int k = 0; k < 3; k++) push_byte(pix_tab[(led % 4) * 3 + k]);
        end
        inj_bit0 = 40; inj_a0 = 4'h0; inj_d0 = 8'h01;
        inj_bit1 = 41; inj_a1 = 4'h1; inj_d1 = 8'h02;
        wr(4'h0, 8'h01);
        check("t2 ctrl busy", data_out, 8'h01);
        check_frame("t2", LATCH + 500, total);
        inj_bit0 = -1; inj_bit1 = -1;
        check("t2 total busy", total, 144 * BITC + LATCH);
        check("t2 busy end", busy, 0);
        address = 4'h0; #1; check("t2 ctrl done", data_out, 8'h02);
        address = 4'h1; #1; check("t2 led_count", data_out, 8'h02);

        // abort during bit 10
        wr(4'h1, 8'd3);
        wr(4'h0, 8'h01);
        check("ab ctrl busy", data_out, 8'h01);
        for (int b = 0; b < 10; b++) begin
            run_len(1'b1, 200, n);
            run_len(1'b0, 200, n);
        end
        check("ab bit10 high", led_out, 1);
        repeat (3) @(negedge clk);
        wr(4'h0, 8'h02);
        check("ab led low", led_out, 0);
        check("ab busy", busy, 1);
        run_busy_low(LATCH + 500, n);
        check("ab latch len", n, LATCH);
        check("ab ctrl done", data_out, 8'h02);

        // zero LED count: latch only
        wr(4'h1, 8'd0);
        wr(4'h0, 8'h01);
        check("z busy", busy, 1);
        check("z led", led_out, 0);
        check("z ctrl", data_out, 8'h01);
        run_busy_low(LATCH + 500, n);
        check("z latch len", n, LATCH);
        check("z ctrl done", data_out, 8'h02);

        // reset while the line is high
        wr(4'h1, 8'd1);
        wr(4'h0, 8'h01);
        repeat (10) @(negedge clk);
        check("rh led high", led_out, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rh led_out", led_out, 0);
        check("rh busy", busy, 0);
        rst = 1'b0;
        address = 4'h0; #1; check("rh ctrl", data_out, 8'h00);

`ifdef WS2812B_BRIGHTNESS_EN
        // BRIGHT=0x7F scales 0xFF to 0x7F
        wr(4'h2, 8'h7F);
        address = 4'h2; #1; check("br read", data_out, 8'h7F);
        wr(4'h4, 8'hFF); wr(4'h1, 8'd1);
        exp_bits.delete();
        push_byte(8'h7F);
        wr(4'h0, 8'h01);
        check_frame("br7f", 0, total);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        // BRIGHT=0xFF leaves the byte unchanged
        wr(4'h2, 8'hFF); wr(4'h4, 8'hFF); wr(4'h1, 8'd1);
        exp_bits.delete();
        push_byte(8'hFF);
        wr(4'h0, 8'h01);
        check_frame("brff", 0, total);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812b_strip_sequencer.md
Name: ws2812b_strip_sequencer

Overview:
- TinyQV byte-bus peripheral that sequences one-wire WS2812B frames from a 4-pixel register buffer onto a single output pin.
- Register interface matches the TinyQV peripheral slot: 4-bit address, byte write strobe, combinational read data.
- Repeats the 4-pixel pattern across up to 255 LEDs, then drives the strip latch (reset) period.
- Sits between the TinyQV core and the WS2812B encoder pin; schedules bit timing, byte fetch, frame length and latch.

Parameters:
- T0H_CYC, 26, high time of a '0' bit in clk cycles (0.40 us at 64 MHz)
- T1H_CYC, 51, high time of a '1' bit in clk cycles (0.80 us)
- BIT_CYC, 80, total bit period in cycles (1.25 us); must exceed T1H_CYC
- LATCH_CYC, 19200, low time after the last bit in cycles (300 us)

Ports:
- clk  in  1  system clock (64 MHz nominal)
- rst  in  1  synchronous, active-high reset
- address  in  4  register address
- data_write  in  1  write strobe; data_in is valid when high
- data_in  in  8  write data
- data_out  out  8  read data; combinational from address
- led_out  out  1  serial WS2812B data line; registered
- busy  out  1  high while a frame or latch is in progress; registered

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: led_out=0, busy=0, done=0, LED_COUNT=0, pixel buffer=0x00, state=IDLE, all counters 0.
- Register map:
  - 0x0 CTRL. Write: bit0 START, bit1 ABORT. Read: {6'b0, done, busy}.
  - 0x1 LED_COUNT, R/W.
  - 0x2, 0x3 read 0; writes ignored.
  - 0x4-0xF pixel buffer. Pixel p, byte k is at 4+3p+k, with k order G,R,B.
- States: IDLE, HIGH, LOW, LATCH.
- IDLE, START written (ABORT=0):
  - Capture LED_COUNT into the frame counter and clear done.
  - If count=0: go to LATCH next cycle.
  - Otherwise: load byte 0 of pixel 0 into the shift register. Next cycle: state=HIGH, led_out=1, busy=1.
- HIGH: led_out=1 for TH cycles, where TH = T1H_CYC if the current MSB is 1, else T0H_CYC. Then go to LOW.
- LOW: led_out=0 for BIT_CYC-TH cycles. Then:
  - Next bit of the byte: shift left, go to HIGH.
  - Byte done: fetch the next byte from the buffer, go to HIGH.
  - Last bit of LED count-1: go to LATCH.
- Bit period is exactly BIT_CYC cycles. Bits are sent MSB first, and there are no gaps between bytes or pixels.
- Pixel index wraps modulo 4: LED n uses pixel n mod 4.
- Byte fetch happens at the first HIGH cycle of each byte. Buffer writes during a frame therefore affect bytes not yet fetched.
- LATCH: led_out=0 for LATCH_CYC cycles. Then IDLE, busy=0, done=1 (sticky until the next START).
- START while busy: ignored. LED_COUNT writes while busy update the register only; the active frame is unaffected.
- ABORT while busy: next cycle led_out=0, state=LATCH with a full LATCH_CYC. done is set at latch end.
- ABORT while idle: no-op. START and ABORT in the same write: ABORT wins, so no frame starts when idle.
- rst mid-frame: immediate return to reset values. led_out=0 on the following edge.
- Counters are sized for LATCH_CYC: 15-bit cycle counter, 5-bit bit/byte counter, 8-bit LED counter.

Optional Feature:
- Macro: WS2812B_BRIGHTNESS_EN.
- Enabled:
  - Address 0x2 is R/W BRIGHT, reset 0xFF.
  - Each fetched byte is scaled to (byte*(BRIGHT+1))>>8 (16-bit product, upper byte taken) before shifting.
  - BRIGHT is sampled at each byte fetch.
- Disabled: 0x2 reads 0, writes are ignored, bytes are sent unscaled.

Test Plan:
- Reset, then read all addresses -> data_out=0x00 everywhere; led_out=0, busy=0.
- Pixel0 = G 0x80, R 0x00, B 0x01; LED_COUNT=1; write CTRL=0x01:
  - led_out rises the next cycle.
  - First bit is high 51 cycles then low 29.
  - Next 22 bits are high 26 / low 54.
  - Last bit is high 51.
  - Then low 19200 cycles; busy falls and CTRL reads 0x02.
- LED_COUNT=6, pixels 0-3 distinct -> 144 bits sent. LEDs 4 and 5 repeat pixels 0 and 1. Total busy = 144*80+19200 cycles.
- Write CTRL=0x02 during bit 10 -> led_out=0 the next cycle and stays low for 19200 cycles; then done=1. A START written mid-frame is ignored; CTRL=0x03 written in IDLE starts nothing.
- LED_COUNT=0 with START -> no high pulses, busy for 19200 cycles, then done=1.
- (WS2812B_BRIGHTNESS_EN) BRIGHT=0x7F, byte 0xFF -> 0x7F transmitted (bit7 '0', bits6-0 '1'). BRIGHT=0xFF -> byte unchanged.
